v6_peak_finder: RTL and testbench

Downstream stage of the v6 shaping filter. Consumes the filtered sample stream, one sample per clock and always valid. Detects pulses crossing a programmable threshold with hysteresis and tracks each pulse's maximum. Reports amplitude, timestamp, width and a pile-up flag through a single-entry valid/ack output register, so the readout logic can drain results at its own pace.

---
 rtl/v6_peak_finder_pkg.sv | 24 ++
 rtl/v6_peak_result_reg.sv | 53 +++++
 rtl/v6_peak_finder.sv | 144 ++++++++++++++
 tb/tb_v6_peak_finder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/v6_peak_finder_pkg.sv
// Shared settings for the v6 peak finder: sample width, default tuning values and FSM encoding.
// Imported by the peak finder top and its result register.
package v6_peak_finder_pkg;

   // Filter output is SIZE_FILTER_DATA+1 bits wide, two's complement.
   localparam int unsigned SIZE_FILTER_DATA = 15;

   localparam int unsigned DEFAULT_HYST      = 16;
   localparam int unsigned DEFAULT_MIN_WIDTH = 3;
   localparam int unsigned DEFAULT_MAX_WIDTH = 64;
   localparam int unsigned DEFAULT_HOLDOFF   = 4;
   localparam int unsigned DEFAULT_TS_WIDTH  = 32;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StHoldoff
   } peak_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/v6_peak_result_reg.sv
// Single-entry valid/ack holding register for peak results; counts results lost while full.
// A result offered in the same cycle as an ack replaces the one being taken.
module v6_peak_result_reg
   import v6_peak_finder_pkg::*;
#(
   parameter int unsigned DW = SIZE_FILTER_DATA + 1,
   parameter int unsigned TW = DEFAULT_TS_WIDTH,
   parameter int unsigned WW = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue,
   input  logic signed [DW-1:0] issue_amplitude,
   input  logic [TW-1:0]        issue_time,
   input  logic [WW-1:0]        issue_width,
   input  logic                 issue_pileup,
   input  logic                 peak_ack,
   output logic                 peak_valid,
   output logic signed [DW-1:0] peak_amplitude,
   output logic [TW-1:0]        peak_time,
   output logic [WW-1:0]        peak_width,
   output logic                 peak_pileup,
   output logic [15:0]          drop_count
);

   logic load;
   assign load = issue && (!peak_valid || peak_ack);

   always_ff @(posedge clk) begin
      if (reset) begin
         peak_valid     <= 1'b0;
         peak_amplitude <= '0;
         peak_time      <= '0;
         peak_width     <= '0;
         peak_pileup    <= 1'b0;
         drop_count     <= '0;
      end else begin
         if (load) begin
            peak_valid     <= 1'b1;
            peak_amplitude <= issue_amplitude;
            peak_time      <= issue_time;
            peak_width     <= issue_width;
            peak_pileup    <= issue_pileup;
         end else if (issue) begin
            // Register full and not being drained: keep the older result.
            drop_count <= sat_inc16(drop_count);
         end else if (peak_ack) begin
            peak_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/v6_peak_finder.sv
// Threshold/hysteresis pulse detector tracking each pulse's maximum, timestamp and width.
// Accepted pulses are handed to a single-entry result register drained by peak_valid/peak_ack.
module v6_peak_finder
   import v6_peak_finder_pkg::*;
#(
   parameter int unsigned HYST      = DEFAULT_HYST,
   parameter int unsigned MIN_WIDTH = DEFAULT_MIN_WIDTH,
   parameter int unsigned MAX_WIDTH = DEFAULT_MAX_WIDTH,
   parameter int unsigned HOLDOFF   = DEFAULT_HOLDOFF,
   parameter int unsigned TS_WIDTH  = DEFAULT_TS_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic signed [SIZE_FILTER_DATA:0]   filter_data,
   input  logic signed [SIZE_FILTER_DATA:0]   threshold,
   input  logic                               peak_ack,
   output logic                               peak_valid,
   output logic signed [SIZE_FILTER_DATA:0]   peak_amplitude,
   output logic [TS_WIDTH-1:0]                peak_time,
   output logic [$clog2(MAX_WIDTH+1)-1:0]     peak_width,
   output logic                               peak_pileup,
   output logic [15:0]                        drop_count,
   output logic                               busy
);

   localparam int unsigned DW = SIZE_FILTER_DATA + 1;
   localparam int unsigned WW = $clog2(MAX_WIDTH + 1);
   localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [WW-1:0]        MAX_W     = WW'(MAX_WIDTH);
   localparam logic [WW-1:0]        MIN_W     = WW'(MIN_WIDTH);
   localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLDOFF - 1);
   localparam logic signed [DW:0]   HYST_EXT  = (DW + 1)'(HYST);

   // Input stage
   logic signed [DW-1:0] x_q;
   logic [TS_WIDTH-1:0]  ts_cnt_q;
   logic [TS_WIDTH-1:0]  ts_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q      <= '0;
         ts_q     <= '0;
         ts_cnt_q <= '0;
      end else begin
         x_q      <= filter_data;
         ts_q     <= ts_cnt_q;
         ts_cnt_q <= ts_cnt_q + 1'b1;
      end
   end

   // One extra bit so threshold - HYST cannot wrap at the negative end.
   logic signed [DW:0] thr_lo;
   logic signed [DW:0] x_ext;
   logic               below_lo;

   assign thr_lo   = {threshold[DW-1], threshold} - HYST_EXT;
   assign x_ext    = {x_q[DW-1], x_q};
   assign below_lo = (x_ext < thr_lo);

   // Pulse tracking FSM
   peak_state_e          state_q;
   logic signed [DW-1:0] max_q;
   logic [TS_WIDTH-1:0]  max_ts_q;
   logic [WW-1:0]        width_q;
   logic                 pileup_q;
   logic [HW-1:0]        hold_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         max_q    <= '0;
         max_ts_q <= '0;
         width_q  <= '0;
         pileup_q <= 1'b0;
         hold_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (x_q > threshold) begin
                  state_q  <= StArmed;
                  max_q    <= x_q;
                  max_ts_q <= ts_q;
                  width_q  <= WW'(1);
                  pileup_q <= (MAX_W == WW'(1));
               end
            end
            StArmed: begin
               if (!below_lo) begin
                  if (width_q != MAX_W) begin
                     width_q <= width_q + WW'(1);
                  end
                  if (width_q >= MAX_W - WW'(1)) begin
                     pileup_q <= 1'b1;
                  end
                  // Strict compare: the earliest of equal maxima keeps its timestamp.
                  if (x_q > max_q) begin
                     max_q    <= x_q;
                     max_ts_q <= ts_q;
                  end
               end else begin
                  state_q <= (HOLDOFF == 0) ? StIdle : StHoldoff;
                  hold_q  <= HOLD_LAST;
               end
            end
            StHoldoff: begin
               if (hold_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  hold_q <= hold_q - HW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // The ending sample is excluded, so the tracked width is already final here.
   logic issue;
   assign issue = (state_q == StArmed) && below_lo && (width_q >= MIN_W);
   assign busy  = (state_q != StIdle);

   v6_peak_result_reg #(
      .DW (DW),
      .TW (TS_WIDTH),
      .WW (WW)
   ) u_result_reg (
      .clk             (clk),
      .reset           (reset),
      .issue           (issue),
      .issue_amplitude (max_q),
      .issue_time      (max_ts_q),
      .issue_width     (width_q),
      .issue_pileup    (pileup_q),
      .peak_ack        (peak_ack),
      .peak_valid      (peak_valid),
      .peak_amplitude  (peak_amplitude),
      .peak_time       (peak_time),
      .peak_width      (peak_width),
      .peak_pileup     (peak_pileup),
      .drop_count      (drop_count)
   );

endmodule

// File: tb/tb_v6_peak_finder.sv
// Directed bench for v6_peak_finder: threshold 100, HYST 10, other parameters at defaults.
// One sample per clock; outputs are sampled 1 time unit after the rising edge.
module tb_v6_peak_finder;

   localparam int unsigned DW = 16;
   localparam int unsigned WW = 7;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic signed [DW-1:0] filter_data = '0;
   logic signed [DW-1:0] threshold = 16'sd100;
   logic                 peak_ack = 1'b0;
   logic                 peak_valid;
   logic signed [DW-1:0] peak_amplitude;
   logic [31:0]          peak_time;
   logic [WW-1:0]        peak_width;
   logic                 peak_pileup;
   logic [15:0]          drop_count;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   int sidx = 0;
   int t_max = 0;

   always #5 clk = ~clk;

   v6_peak_finder #(
      .HYST      (10),
      .MIN_WIDTH (3),
      .MAX_WIDTH (64),
      .HOLDOFF   (4),
      .TS_WIDTH  (32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .filter_data    (filter_data),
      .threshold      (threshold),
      .peak_ack       (peak_ack),
      .peak_valid     (peak_valid),
      .peak_amplitude (peak_amplitude),
      .peak_time      (peak_time),
      .peak_width     (peak_width),
      .peak_pileup    (peak_pileup),
      .drop_count     (drop_count),
      .busy           (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Present one sample, clock it in, and advance the sample index (= its ts_r).
   task automatic step(input int x);
      filter_data = 16'(x);
      @(posedge clk);
      #1;
      sidx++;
   endtask

   task automatic step_n(input int x, input int n);
      for (int i = 0; i < n; i++) step(x);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, ".valid"}, 64'(peak_valid), 0);
      check({tag, ".busy"}, 64'(busy), 0);
      check({tag, ".amp"}, 64'(peak_amplitude), 0);
      check({tag, ".time"}, 64'(peak_time), 0);
      check({tag, ".width"}, 64'(peak_width), 0);
      check({tag, ".pileup"}, 64'(peak_pileup), 0);
      check({tag, ".drop"}, 64'(drop_count), 0);
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      reset = 1'b0;
      sidx  = 0;

      // Pulse 0,50,150,300,200,120,95,80,0; 95 stays armed through hysteresis
      step(0);
      step(50);
      step(150);
      check("p1.busy_before", 64'(busy), 0);
      t_max = sidx;
      step(300);
      check("p1.busy_after", 64'(busy), 1);
      step(200);
      step(120);
      step(95);
      step(80);                       // ending sample, end index e
      check("p1.valid_e0", 64'(peak_valid), 0);
      step(0);                        // e+1
      check("p1.valid_e1", 64'(peak_valid), 1);
      check("p1.amp", 64'(peak_amplitude), 300);
      check("p1.time", 64'(peak_time), 64'(t_max));
      check("p1.width", 64'(peak_width), 5);
      check("p1.pileup", 64'(peak_pileup), 0);

      // Holdoff: 200 at e+2 ignored, 200 at e+5 arms
      peak_ack = 1'b1;
      step(200);                      // e+2
      peak_ack = 1'b0;
      check("p1.ack_clears", 64'(peak_valid), 0);
      check("hold.busy_mid", 64'(busy), 1);
      step(0);                        // e+3
      step(0);                        // e+4
      step(200);                      // e+5
      check("hold.idle_at_end", 64'(busy), 0);
      step(0);                        // e+6
      check("hold.rearm", 64'(busy), 1);
      step_n(0, 8);
      check("hold.no_result", 64'(peak_valid), 0);

      // Glitch of width 2 is discarded
      step(0);
      step(150);
      step(150);
      step(0);
      step_n(0, 8);
      check("glitch.valid", 64'(peak_valid), 0);
      check("glitch.drop", 64'(drop_count), 0);

      // 70 samples of 500 saturate width and flag pile-up
      t_max = sidx;
      step_n(500, 70);
      step(0);
      check("pile.valid_e0", 64'(peak_valid), 0);
      step(0);
      check("pile.valid", 64'(peak_valid), 1);
      check("pile.amp", 64'(peak_amplitude), 500);
      check("pile.time", 64'(peak_time), 64'(t_max));
      check("pile.width", 64'(peak_width), 64);
      check("pile.pileup", 64'(peak_pileup), 1);
      peak_ack = 1'b1;
      step(0);
      peak_ack = 1'b0;
      step_n(0, 6);
      check("pile.acked", 64'(peak_valid), 0);

      // Backpressure: second result dropped, first held
      t_max = sidx;
      step_n(200, 4);
      step_n(0, 7);
      step_n(300, 4);
      step_n(0, 7);
      check("bp.valid", 64'(peak_valid), 1);
      check("bp.amp", 64'(peak_amplitude), 200);
      check("bp.time", 64'(peak_time), 64'(t_max));
      check("bp.width", 64'(peak_width), 4);
      check("bp.drop", 64'(drop_count), 1);

      // Third result issued in the same cycle as the ack replaces the held one
      t_max = sidx;
      step_n(400, 4);
      step(0);                        // ending sample
      peak_ack = 1'b1;
      step(0);                        // issue edge
      peak_ack = 1'b0;
      check("bp3.valid", 64'(peak_valid), 1);
      check("bp3.amp", 64'(peak_amplitude), 400);
      check("bp3.time", 64'(peak_time), 64'(t_max));
      check("bp3.drop", 64'(drop_count), 1);
      step_n(0, 6);

      // Reset mid-pulse with a result still held
      step_n(300, 3);
      check("rst.pre_busy", 64'(busy), 1);
      check("rst.pre_valid", 64'(peak_valid), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_cleared("rst");
      reset = 1'b0;
      sidx  = 0;

      // Timestamp restarts at 0 after reset
      step(0);
      step(150);
      step(250);
      step(200);
      step(150);
      step(0);
      step(0);
      check("ts.valid", 64'(peak_valid), 1);
      check("ts.amp", 64'(peak_amplitude), 250);
      check("ts.time", 64'(peak_time), 2);
      check("ts.width", 64'(peak_width), 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
